// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand feeder and the accumulate unit it drives.
package mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESULT = 3'd4
    } mac_feeder_state_t;

    // Accumulator width used by both the MAC and the feeder's result register.
    function automatic int unsigned acc_width(input int unsigned data_width);
        return 3 * data_width;
    endfunction

endpackage

// File: rtl/mac_feeder.sv
// Transaction sequencer: clears the MAC, streams len operand pairs into it,
// then captures the accumulator and offers it on a valid/ready result port.
module mac_feeder
    import mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8,
    localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  mac_en,
    output logic                  mac_clr,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    input  logic [ACC_WIDTH-1:0]  mac_cout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data
);

    mac_feeder_state_t    state, state_nxt;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 accept;

    assign busy      = (state != ST_IDLE);
    assign op_ready  = (state == ST_STREAM);
    assign accept    = op_valid & op_ready;
    assign mac_en    = accept;
    assign mac_clr   = (state == ST_CLR);
    assign res_valid = (state == ST_RESULT);
    assign mac_a     = accept ? op_a : '0;
    assign mac_b     = accept ? op_b : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_CLR;
            ST_CLR:    state_nxt = (remaining != '0) ? ST_STREAM : ST_WAIT;
            ST_STREAM: if (accept && remaining == LEN_WIDTH'(1)) state_nxt = ST_WAIT;
            ST_WAIT:   state_nxt = ST_RESULT;
            ST_RESULT: if (res_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            res_data  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start)
                remaining <= len;
            else if (accept)
                remaining <= remaining - LEN_WIDTH'(1);
            // The MAC register already holds the last product during WAIT.
            if (state == ST_WAIT)
                res_data <= mac_cout;
        end
    end

endmodule
